// File: rtl/rv32_pkg.sv
// RV32 base opcodes, immediate formats and decode helpers shared by the ID stage.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

  function automatic imm_fmt_e get_imm_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return IMM_I;
      OP_STORE:                            return IMM_S;
      OP_BRANCH:                           return IMM_B;
      OP_LUI, OP_AUIPC:                    return IMM_U;
      OP_JAL:                              return IMM_J;
      default:                             return IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e f);
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic idx_in_range(input logic [4:0] idx, input int unsigned n);
    return 32'(idx) < n;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two async read ports with write-back bypass, one sync write port.
module id_regfile import rv32_pkg::*; #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0) && idx_in_range(waddr_i, NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  // x0 and out-of-range indices read as zero; a same-cycle write is forwarded.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != 5'd0 && idx_in_range(raddr1_i, NUM_REGS)) begin
      rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i[AW-1:0]];
    end
    if (raddr2_i != 5'd0 && idx_in_range(raddr2_i, NUM_REGS)) begin
      rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i[AW-1:0]];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32 instruction-decode stage: field decode, immediate generation, operand read and a
// handshaked ID/EX register with operand refresh while stalled.
module id_stage import rv32_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_func3,
  output logic [6:0]      id_func7,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [XLEN-1:0] id_r1,
  output logic [XLEN-1:0] id_r2,
  output logic [XLEN-1:0] id_imm,
  output logic            id_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } idex_t;

  idex_t           idex_d, idex_q, dec;
  logic            valid_d, valid_q;
  logic            accept, stall;
  logic [XLEN-1:0] rdata1, rdata2;
  imm_fmt_e        fmt;
  logic            uses_rd, uses_rs1, uses_rs2;

  id_regfile #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (if_instr[19:15]),
    .rdata1_o (rdata1),
    .raddr2_i (if_instr[24:20]),
    .rdata2_o (rdata2)
  );

  assign if_ready = !valid_q || id_ready;
  assign accept   = if_valid && if_ready && !flush;
  assign stall    = valid_q && !id_ready;

  always_comb begin
    fmt      = get_imm_fmt(if_instr[6:0]);
    uses_rd  = !(fmt == IMM_S || fmt == IMM_B);
    uses_rs1 = !(fmt == IMM_U || fmt == IMM_J);
    uses_rs2 = (fmt == IMM_S) || (fmt == IMM_B) || (if_instr[6:0] == OP_REG);

    dec         = '0;
    dec.pc      = if_pc;
    dec.opcode  = if_instr[6:0];
    dec.func3   = if_instr[14:12];
    dec.func7   = if_instr[31:25];
    dec.rd      = if_instr[11:7];
    dec.rs1     = if_instr[19:15];
    dec.rs2     = if_instr[24:20];
    dec.r1      = rdata1;
    dec.r2      = rdata2;
    dec.imm     = XLEN'($signed(gen_imm(if_instr, fmt)));
    dec.illegal = !op_legal(if_instr[6:0])
                || (uses_rd  && !idx_in_range(if_instr[11:7],  NUM_REGS))
                || (uses_rs1 && !idx_in_range(if_instr[19:15], NUM_REGS))
                || (uses_rs2 && !idx_in_range(if_instr[24:20], NUM_REGS));
  end

  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      idex_d  = dec;
    end else begin
      if (valid_q && id_ready) valid_d = 1'b0;
      // Keep held operands coherent with write-backs that land during a long stall.
      if (stall && wb_we) begin
        if (wb_rd == idex_q.rs1 && idex_q.rs1 != 5'd0 && idx_in_range(idex_q.rs1, NUM_REGS)) begin
          idex_d.r1 = wb_data;
        end
        if (wb_rd == idex_q.rs2 && idex_q.rs2 != 5'd0 && idx_in_range(idex_q.rs2, NUM_REGS)) begin
          idex_d.r2 = wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign id_valid   = valid_q;
  assign id_pc      = idex_q.pc;
  assign id_opcode  = idex_q.opcode;
  assign id_func3   = idex_q.func3;
  assign id_func7   = idex_q.func7;
  assign id_rd      = idex_q.rd;
  assign id_rs1     = idex_q.rs1;
  assign id_rs2     = idex_q.rs2;
  assign id_r1      = idex_q.r1;
  assign id_r2      = idex_q.r2;
  assign id_imm     = idex_q.imm;
  assign id_illegal = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage (RV32E register count) with a scoreboard of expected decodes.
module tb_id_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid, if_ready, flush, wb_we, id_valid, id_ready, id_illegal;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc, wb_data, id_pc, id_r1, id_r2, id_imm;
  logic [4:0]      wb_rd, id_rd, id_rs1, id_rs2;
  logic [6:0]      id_opcode, id_func7;
  logic [2:0]      id_func3;

  always #5 clk = ~clk;

  id_stage #(
    .XLEN     (XLEN),
    .NUM_REGS (NREGS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_opcode  (id_opcode),
    .id_func3   (id_func3),
    .id_func7   (id_func7),
    .id_rd      (id_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_r1      (id_r1),
    .id_r2      (id_r2),
    .id_imm     (id_imm),
    .id_illegal (id_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_rf [NREGS];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 5'd0 || 32'(a) >= NREGS) return 32'h0;
    if (we && wrd == a) return wd;
    return ref_rf[int'(a)];
  endfunction

  task automatic wb_commit(input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    if (we && wrd != 5'd0 && 32'(wrd) < NREGS) ref_rf[int'(wrd)] = wd;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                       input logic ill, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd);
    exp_t e;
    e.instr   = instr;
    e.pc      = pc;
    e.r1      = model_rd(instr[19:15], we, wrd, wd);
    e.r2      = model_rd(instr[24:20], we, wrd, wd);
    e.imm     = imm;
    e.illegal = ill;
    sb.push_back(e);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    wb_we    = we;
    wb_rd    = wrd;
    wb_data  = wd;
    @(posedge clk); #1;
    wb_commit(we, wrd, wd);
    if_valid = 1'b0;
    wb_we    = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] wrd, input logic [31:0] wd);
    wb_we   = 1'b1;
    wb_rd   = wrd;
    wb_data = wd;
    @(posedge clk); #1;
    wb_commit(1'b1, wrd, wd);
    wb_we = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 32'(id_valid), 32'd1);
    chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, ".pc"},      id_pc,             e.pc);
    chk({tag, ".opcode"},  32'(id_opcode),    32'(e.instr[6:0]));
    chk({tag, ".func3"},   32'(id_func3),     32'(e.instr[14:12]));
    chk({tag, ".func7"},   32'(id_func7),     32'(e.instr[31:25]));
    chk({tag, ".rd"},      32'(id_rd),        32'(e.instr[11:7]));
    chk({tag, ".rs1"},     32'(id_rs1),       32'(e.instr[19:15]));
    chk({tag, ".rs2"},     32'(id_rs2),       32'(e.instr[24:20]));
    chk({tag, ".r1"},      id_r1,             e.r1);
    chk({tag, ".r2"},      id_r2,             e.r2);
    chk({tag, ".imm"},     id_imm,            e.imm);
    chk({tag, ".illegal"}, 32'(id_illegal),   32'(e.illegal));
  endtask

  initial begin
    exp_t dropped;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; id_ready = 1'b1;
    for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid",    32'(id_valid),   32'd0);
    chk("rst.imm",      id_imm,          32'h0);
    chk("rst.pc",       id_pc,           32'h0);
    chk("rst.r1",       id_r1,           32'h0);
    chk("rst.illegal",  32'(id_illegal), 32'd0);
    chk("rst.if_ready", 32'(if_ready),   32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic decode, bypass and immediate formats.
    issue(32'hFFB00093, 32'h100, 32'hFFFFFFFB, 1'b0, 1'b0, 5'd0, 32'h0); check_out("addi");
    issue(32'h00528333, 32'h104, 32'h0,        1'b0, 1'b1, 5'd5, 32'h1234); check_out("add_byp");
    issue(32'hFE000EE3, 32'h108, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 32'h0); check_out("beq_a");
    issue(32'hFE000E63, 32'h10C, 32'hFFFFF7FC, 1'b0, 1'b0, 5'd0, 32'h0); check_out("beq_b");
    issue(32'h12345237, 32'h110, 32'h12345000, 1'b0, 1'b0, 5'd0, 32'h0); check_out("lui");
    issue(32'hFFDFF0EF, 32'h114, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 32'h0); check_out("jal_neg");
    issue(32'h0010006F, 32'h118, 32'h00000800, 1'b0, 1'b0, 5'd0, 32'h0); check_out("jal_b11");
    issue(32'hFE50AC23, 32'h11C, 32'hFFFFFFF8, 1'b0, 1'b0, 5'd0, 32'h0); check_out("sw");
    @(posedge clk); #1;
    chk("drain.valid", 32'(id_valid), 32'd0);

    // Long stall with operand refresh on rs1=x2.
    id_ready = 1'b0;
    issue(32'h00110193, 32'h200, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0);
    if_valid = 1'b1; if_instr = 32'h00000013; if_pc = 32'h204;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hAA;
    #1;
    chk("stall.if_ready", 32'(if_ready), 32'd0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    wb_commit(1'b1, 5'd2, 32'hAA);
    sb[0].r1 = 32'hAA;
    chk("stall.r1_refresh", id_r1, 32'hAA);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall.pc_held",  id_pc,  32'h200);
      chk("stall.imm_held", id_imm, 32'h1);
    end
    if_valid = 1'b0;
    id_ready = 1'b1;
    check_out("stall_rel");
    @(posedge clk); #1;
    chk("stall.after_valid", 32'(id_valid), 32'd0);

    // Flush beats a held instruction and an incoming one; x0 stays zero.
    id_ready = 1'b0;
    issue(32'h00028413, 32'h300, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    flush = 1'b1; if_valid = 1'b1; if_instr = 32'h00110193; if_pc = 32'h304;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    chk("flush.valid", 32'(id_valid), 32'd0);
    dropped = sb.pop_front();
    id_ready = 1'b1;
    wb_write(5'd0, 32'hDEAD);
    issue(32'h000003B3, 32'h308, 32'h0, 1'b0, 1'b1, 5'd0, 32'hBEEF); check_out("x0_read");

    // Register-count boundaries for the 16-entry file.
    wb_write(5'd4,  32'h55);
    wb_write(5'd15, 32'h77);
    issue(32'h014100B3, 32'h400, 32'h0,        1'b1, 1'b0, 5'd0, 32'h0); check_out("rs2_x20");
    issue(32'h010780B3, 32'h404, 32'h0,        1'b1, 1'b0, 5'd0, 32'h0); check_out("rs2_x16");
    issue(32'hFFF78793, 32'h408, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'h0); check_out("addi_x15");
    issue(32'h0000007F, 32'h40C, 32'h0,        1'b1, 1'b0, 5'd0, 32'h0); check_out("op_7f");
    issue(32'h0000000F, 32'h410, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0); check_out("fence");
    issue(32'h12345A37, 32'h414, 32'h12345000, 1'b1, 1'b0, 5'd0, 32'h0); check_out("lui_x20");

    // Asynchronous reset during a stall discards the held instruction and clears registers.
    id_ready = 1'b0;
    issue(32'h00110193, 32'h500, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid.valid", 32'(id_valid), 32'd0);
    chk("rst_mid.r1",    id_r1,         32'h0);
    sb.delete();
    for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    id_ready = 1'b1;
    issue(32'h00110193, 32'h504, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0); check_out("after_rst");

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
